// File: rtl/sys_reset_ctrl.sv
// rtl/sys_reset_ctrl.sv - reset sequencer: pin sync, hold stretch, staggered per-channel release
//
// Purpose: turns the raw board reset into synchronised, stretched, staggered
// active-high resets, one per consumer. Adds software and watchdog reset
// sources and records the last reset cause and a saturating reset count.
//
// Ports:
//   clk_in      in   system clock, rising edge
//   sys_rstn    in   asynchronous active-low board reset
//   sw_rst_req  in   software reset request, level-sampled each edge
//   wdt_kick    in   watchdog service strobe (ignored when WDT_EN=0)
//   rst_out     out  per-channel active-high resets, bit 0 released first
//   ready       out  all channels released and sequencer in RUN
//   rst_cause   out  last reset cause: 00 pin, 01 software, 10 watchdog
//   rst_count   out  soft/watchdog resets since last pin reset, saturates at 255
module sys_reset_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 50,
  parameter int STAGGER     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WDT_EN      = 0,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic              clk_in,
  input  logic              sys_rstn,
  input  logic              sw_rst_req,
  input  logic              wdt_kick,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ready,
  output logic [1:0]        rst_cause,
  output logic [7:0]        rst_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int WW = $clog2(WDT_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
  localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_CYCLES - 1);

  localparam logic [1:0] CAUSE_PIN = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q,  sync_d;
  logic [HW-1:0]          hold_q,  hold_d;
  logic [SW-1:0]          stag_q,  stag_d;
  logic [WW-1:0]          wdt_q,   wdt_d;
  logic [NUM_CH-1:0]      rst_q,   rst_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;
  logic [7:0]             count_q, count_d;
  logic                   sw_hit;
  logic                   wdt_hit;

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= ST_SYNC;
      sync_q  <= '0;
      hold_q  <= '0;
      stag_q  <= '0;
      wdt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_PIN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      wdt_q   <= wdt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    hold_d  = hold_q;
    stag_d  = stag_q;
    wdt_d   = wdt_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    count_d = count_q;

    sw_hit  = sw_rst_req && ((state_q == ST_RELEASE) || (state_q == ST_RUN));
    // A kick on the expiry edge clears the counter instead of firing.
    wdt_hit = (WDT_EN != 0) && (state_q == ST_RUN) && !wdt_kick && (wdt_q == WDT_LAST);

    case (state_q)
      ST_SYNC: begin
        // The chain only ever fills once after a pin reset, so the edge on
        // which its last stage rises is the start of the hold period.
        if (sync_d[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          // Channels are released as a thermometer: shifting in a zero
          // drops the lowest still-asserted channel.
          rst_d  = rst_q << 1;
          stag_d = '0;
          if (rst_d == '0) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stag_q == STAG_LAST) begin
          rst_d  = rst_q << 1;
          stag_d = '0;
          if (rst_d == '0) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          stag_d = stag_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (WDT_EN != 0) begin
          wdt_d = wdt_kick ? '0 : wdt_q + 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // Software request takes precedence over a coincident watchdog expiry;
    // either way the count moves by one.
    if (sw_hit || wdt_hit) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      stag_d  = '0;
      wdt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      cause_d = sw_hit ? CAUSE_SW : CAUSE_WDT;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  assign rst_out   = rst_q;
  assign ready     = ready_q;
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule
